// File: rtl/riscv_wb_pkg.sv
// Shared Wishbone types for the SRAM responder: bus field widths, the response
// record carried down the latency pipe, and the sweep/ready state encoding.
package riscv_wb_pkg;

  typedef logic [29:0] wb_addr_t;
  typedef logic [31:0] wb_data_t;
  typedef logic [3:0]  wb_sel_t;

  typedef struct packed {
    logic     valid;
    logic     err;
    wb_data_t data;
  } wb_resp_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

endpackage

// File: rtl/riscv_wb_resp_pipe.sv
// Fixed-latency in-order response shift register; flush drops everything in
// flight, including the entry that would have surfaced on the same edge.
module riscv_wb_resp_pipe
  import riscv_wb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     reset_ni,
  input  logic     flush_i,
  input  wb_resp_t resp_i,
  output wb_resp_t resp_o
);

  wb_resp_t stage_q [LATENCY];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= resp_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/riscv_wb_sram.sv
// Wishbone B4 pipelined SRAM responder: byte-lane writes, range errors,
// fixed-latency in-order responses and an optional post-reset zero sweep.
module riscv_wb_sram
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic     clk_i,
  input  logic     reset_ni,
  input  logic     wb_cyc_i,
  input  logic     wb_stb_i,
  input  logic     wb_we_i,
  input  wb_addr_t wb_addr_i,
  input  wb_sel_t  wb_sel_i,
  input  wb_data_t wb_data_i,
  output logic     wb_ack_o,
  output logic     wb_err_o,
  output logic     wb_stall_o,
  output wb_data_t wb_data_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  typedef logic [AW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(DEPTH_WORDS - 1);

  sram_state_e state_q, state_d;
  idx_t        sweep_q, sweep_d;
  logic        sweep_we;

  wb_data_t    mem [DEPTH_WORDS];

  logic        accept, in_range;
  idx_t        idx;
  wb_resp_t    req_resp, out_resp;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Stall comes from state alone so it can never form a loop with the initiator.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    sweep_we   = 1'b0;
    wb_stall_o = 1'b1;
    unique case (state_q)
      INIT: begin
        if (CLEAR_ON_RESET) begin
          sweep_we = 1'b1;
          sweep_d  = sweep_q + idx_t'(1);
          if (sweep_q == LAST_IDX) state_d = READY;
        end else begin
          state_d = READY;
        end
      end
      READY: wb_stall_o = 1'b0;
    endcase
  end

  assign accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign in_range = {2'b00, wb_addr_i} < 32'(DEPTH_WORDS);
  assign idx      = wb_addr_i[AW-1:0];

  // Requests are never accepted while sweeping, so the two write sources are exclusive.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      mem[sweep_q] <= '0;
    end else if (accept && wb_we_i && in_range) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_data_i[8*b +: 8];
    end
  end

  always_comb begin
    req_resp       = '0;
    req_resp.valid = accept;
    req_resp.err   = accept & ~in_range;
    if (accept && in_range && !wb_we_i) req_resp.data = mem[idx];
  end

  riscv_wb_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .flush_i  (~wb_cyc_i),
    .resp_i   (req_resp),
    .resp_o   (out_resp)
  );

  assign wb_ack_o  = out_resp.valid & ~out_resp.err;
  assign wb_err_o  = out_resp.valid &  out_resp.err;
  assign wb_data_o = out_resp.data;

endmodule

// File: tb/tb_riscv_wb_sram.sv
// Scoreboard bench for riscv_wb_sram: a reference model queues expected
// responses at acceptance; a negedge monitor pops and compares them.
module tb_riscv_wb_sram;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [29:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic        ack, err, stall;
  logic [31:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  riscv_wb_sram #(
    .DEPTH_WORDS    (DEPTH),
    .LATENCY        (LAT),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_addr_i  (addr),
    .wb_sel_i   (sel),
    .wb_data_i  (wdata),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_stall_o (stall),
    .wb_data_o  (rdata)
  );

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          edge_n = 0;
  int          init_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: spec rules applied per edge on the sampled bus.
  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      init_n = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (init_n < DEPTH) begin
        init_n++;
        if (init_n == DEPTH) foreach (ref_mem[i]) ref_mem[i] = '0;
      end else if (!cyc) begin
        exp_q.delete();
      end else if (stb) begin
        exp_t        e;
        logic [31:0] mask;
        e.due  = edge_n + LAT - 1;
        e.err  = (32'(addr) >= DEPTH);
        e.data = '0;
        if (!e.err) begin
          if (we) begin
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            ref_mem[addr] = (ref_mem[addr] & ~mask) | (wdata & mask);
          end else begin
            e.data = ref_mem[addr];
          end
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every cycle either the head response is due or the bus must be quiet.
  always @(negedge clk_i) begin
    if (!reset_ni) begin
      check("rst_ack",   32'(ack),   32'(0));
      check("rst_err",   32'(err),   32'(0));
      check("rst_stall", 32'(stall), 32'(1));
      check("rst_data",  rdata,      32'(0));
    end else begin
      check("stall", 32'(stall), 32'(init_n < DEPTH));
      if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_ack",  32'(ack), 32'(!e.err));
        check("resp_err",  32'(err), 32'(e.err));
        check("resp_data", rdata,    e.data);
      end else begin
        check("idle_ack", 32'(ack), 32'(0));
        check("idle_err", 32'(err), 32'(0));
      end
    end
  end

  task automatic drive(input bit c, input bit s, input bit w, input logic [29:0] a,
                       input logic [3:0] sl, input logic [31:0] d);
    cyc = c; stb = s; we = w; addr = a; sel = sl; wdata = d;
    @(negedge clk_i);
  endtask

  initial begin
    #1 reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    // Hit reset again mid-sweep; the sweep must restart from word 0.
    repeat (6) @(negedge clk_i);
    reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    // Read of addr 5 held through the whole sweep.
    repeat (DEPTH + 2) drive(1, 1, 0, 30'd5, 4'h0, 32'h0);

    drive(1, 1, 1, 30'd3, 4'hF, 32'hDEADBEEF);
    drive(1, 1, 0, 30'd3, 4'h0, 32'h0);
    drive(1, 1, 1, 30'd3, 4'b0101, 32'h11223344);
    drive(1, 1, 0, 30'd3, 4'h0, 32'h0);
    drive(1, 1, 1, 30'd3, 4'h0, 32'hFFFFFFFF);
    drive(1, 1, 0, 30'd3, 4'hF, 32'h0);
    drive(1, 1, 0, 30'd16, 4'hF, 32'h0);
    drive(1, 1, 1, 30'h3FFFFFFF, 4'hF, 32'hCAFEF00D);
    drive(1, 1, 1, 30'd0, 4'hF, 32'hA0A0A0A0);
    drive(1, 1, 1, 30'd1, 4'hF, 32'hB1B1B1B1);
    drive(1, 1, 1, 30'd2, 4'hF, 32'hC2C2C2C2);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 30'(i), 4'h0, 32'h0);
    drive(1, 1, 0, 30'd15, 4'h0, 32'h0);
    repeat (LAT + 1) drive(1, 0, 0, 30'd0, 4'h0, 32'h0);

    // Abort: two reads in flight, then cyc drops.
    drive(1, 1, 0, 30'd1, 4'h0, 32'h0);
    drive(1, 1, 0, 30'd2, 4'h0, 32'h0);
    drive(0, 0, 0, 30'd0, 4'h0, 32'h0);
    repeat (LAT + 2) drive(1, 0, 0, 30'd0, 4'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      bit          c, s, w;
      logic [29:0] a;
      c = ($urandom_range(0, 19) != 0);
      s = ($urandom_range(0, 9) < 7);
      w = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) a = 30'h3FFFFFF0 + 30'($urandom_range(0, 15));
      else                           a = 30'($urandom_range(0, DEPTH + 3));
      drive(c, s, w, a, 4'($urandom_range(0, 15)), $urandom);
    end

    repeat (LAT + 2) drive(1, 0, 0, 30'd0, 4'h0, 32'h0);
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_wb_sram.md
# riscv_wb_sram

Wishbone B4 pipelined responder: single-port word-addressed SRAM with byte-lane writes, fixed-latency in-order responses, address-range errors, and an optional post-reset clear sweep. Sits on the far side of the bus from the fetch and load/store initiators. It is the instruction/data memory that answers `wb_cyc/wb_stb` requests with `wb_ack`/`wb_err` and honours `wb_stall`.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; any value ≥ 2.
- `LATENCY`, 1: edges from request acceptance to response; legal range 1–4.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset, stalling meanwhile; 0 = no sweep.

Ports:
- `clk_i` in 1: the single clock.
- `reset_ni` in 1: reset, asynchronous, active-low.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: request strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_addr_i` in 30: word address.
- `wb_sel_i` in 4: byte-lane enables; bit n covers data[8n+7:8n].
- `wb_data_i` in 32: write data.
- `wb_ack_o` out 1: successful response, one cycle per accepted request.
- `wb_err_o` out 1: error response, replaces ack.
- `wb_stall_o` out 1: request not accepted this cycle.
- `wb_data_o` out 32: read data, valid only with ack of a read.

## Operation
- Accept condition: `wb_cyc_i && wb_stb_i && !wb_stall_o`, sampled at a rising edge.
- Each accepted request produces exactly one response, ack or err, never both, in acceptance order.
- Range check: a request is in range when the full 30-bit `wb_addr_i < DEPTH_WORDS`. The array index is the low `$clog2(DEPTH_WORDS)` bits.
- In-range write:
  - Commits on the accept edge.
  - Only lanes with `wb_sel_i` set are written; `sel=0` is legal and writes nothing.
  - Responds with ack; `wb_data_o` = 0.
- In-range read:
  - Ignores `wb_sel_i` and returns the full word.
  - Sees every write accepted on an earlier edge, including back-to-back write→read of the same address.
- Out-of-range request: no array access; responds with err; `wb_data_o` = 0.
- Abort: if `wb_cyc_i` is sampled low, all in-flight responses are discarded on that edge. Writes already committed stay committed. No ack/err appears until new requests are accepted.
- State machine (`CLEAR_ON_RESET=1`):
  - INIT: counter sweeps 0..DEPTH_WORDS-1, writing one zero word per cycle. `wb_stall_o`=1 throughout. After the last word, go to READY.
  - READY: `wb_stall_o`=0; accept one request per cycle.
- With `CLEAR_ON_RESET=0`, the block enters READY on the first edge after reset release. Array contents are undefined until written.

## Timing
- Reset asserted (async): response pipeline valid bits cleared; `wb_ack_o`=0, `wb_err_o`=0, `wb_data_o`=0, `wb_stall_o`=1; FSM→INIT (or READY per parameter); sweep counter=0.
- Reset asserted mid-sweep restarts the sweep at word 0. Reset never touches array contents except through the sweep.
- Sweep length: with `CLEAR_ON_RESET=1`, `wb_stall_o` falls exactly DEPTH_WORDS edges after reset release.
- Latency: request accepted at edge N produces `wb_ack_o`/`wb_err_o` high during the cycle after edge N+LATENCY-1. LATENCY=1 therefore responds in the cycle immediately after acceptance.
- All outputs are registered except `wb_stall_o`, which is decoded from FSM state only and never depends on `wb_*_i`.
- Throughput: one request per cycle in READY; up to LATENCY responses outstanding. No backpressure from the initiator exists; responses are never delayed.
- Simultaneous `wb_cyc_i` low and a response due at that edge: the response is dropped.

## Structure
- Shared package `riscv_wb_pkg` holds:
  - `wb_addr_t` (logic [29:0]), `wb_data_t` (logic [31:0]), `wb_sel_t` (logic [3:0]);
  - the response struct `wb_resp_t` {valid, err, data};
  - the FSM enum `sram_state_e` {INIT, READY}.
- Sub-module `riscv_wb_resp_pipe`: LATENCY-deep shift register of `wb_resp_t`, with flush input for the abort. The top module owns the array, byte-lane write, range check and FSM.

## Test plan
- `CLEAR_ON_RESET=1`, `DEPTH_WORDS=16`: release reset, hold a read request → stall high exactly 16 edges, then read addr 5 acks with data 0x00000000.
- LATENCY=1: write 0xDEADBEEF to addr 3 with sel=4'b1111, then read addr 3 on the next cycle → acks on consecutive cycles; read ack carries 0xDEADBEEF.
- Byte lanes: addr 3 holds 0xDEADBEEF; write 0x11223344 with sel=4'b0101 → read returns 0xDE22BE44.
- LATENCY=3: stream 4 reads to addrs 0..3 with stb held high → 4 acks on consecutive cycles starting 3 edges after the first accept, data in address order.
- `DEPTH_WORDS=16`: read addr 16 and write addr 0x3FFFFFFF → err only, no ack, data 0, array unchanged.
- LATENCY=4: accept 2 reads, drop `wb_cyc_i` on the next edge → no ack/err ever; assert `reset_ni` low mid-sweep → stall stays high and the sweep restarts at 0.
